// File: rtl/stage2_pkg.sv
// Shared constants, stage codes and FSM state type for the stage-2 feeder.
// Imported by stage2_fifo and stage2_feeder.
package stage2_pkg;

    localparam int WIDTH = 16;
    localparam int LANES = 2;
    localparam int PARA  = 8;
    localparam int N     = 4096;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] STG_0 = 3'd0;
    localparam logic [2:0] STG_1 = 3'd1;
    localparam logic [2:0] STG_2 = 3'd2;
    localparam logic [2:0] STG_3 = 3'd3;
    localparam logic [2:0] STG_4 = 3'd4;
    localparam logic [2:0] STG_5 = 3'd5;
    localparam logic [2:0] STG_6 = 3'd6;
    localparam logic [2:0] STG_7 = 3'd7;

    // Stages whose results are worth writing back when filtering is on.
    function automatic logic wb_stage_sel(input logic [2:0] stg);
        return (stg == STG_5) || (stg == STG_6);
    endfunction

endpackage

// File: rtl/stage2_fifo.sv
// Input FIFO holding {norm, scale, operand} beats, DEPTH entries (power of 2).
// Ports: CLK_i, RST_i, push_i, pop_i, data_i, data_o (head), full_o, empty_o.
module stage2_fifo #(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                         CLK_i,
    input  logic                         RST_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [3*LANES*WIDTH-1:0]     data_i,
    output logic [3*LANES*WIDTH-1:0]     data_o,
    output logic                         full_o,
    output logic                         empty_o
);
    import stage2_pkg::*;

    localparam int DW = 3 * LANES * WIDTH;
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == (AW + 1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge CLK_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stage2_feeder.sv
// Feeds FIFO'd operand beats into the stage-2 pipeline and registers results
// for writeback. Ports: CLK_i/RST_i, start_i/busy_o/done_o control, upstream
// in_* valid/ready, pipeline drive (stall_o, operand/scale/norm/pos), pipeline
// return (stage_i, finished_i, res1/res2), writeback wb_* valid/ready.
// Optional macro STAGE2_FEEDER_WB_FILTER_EN: capture only in stages 5 and 6.
module stage2_feeder #(
    parameter int WIDTH = stage2_pkg::WIDTH,
    parameter int LANES = stage2_pkg::LANES,
    parameter int PARA  = stage2_pkg::PARA,
    parameter int DEPTH = 4
) (
    input  logic                     CLK_i,
    input  logic                     RST_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [LANES*WIDTH-1:0]   in_operand_i,
    input  logic [LANES*WIDTH-1:0]   in_scale_i,
    input  logic [LANES*WIDTH-1:0]   in_norm_i,
    output logic                     stall_o,
    output logic [LANES*WIDTH-1:0]   operand_o,
    output logic [LANES*WIDTH-1:0]   scale_o,
    output logic [LANES*WIDTH-1:0]   norm_o,
    output logic [LANES*WIDTH-1:0]   pos_o,
    input  logic [2:0]               stage_i,
    input  logic                     finished_i,
    input  logic [LANES*WIDTH-1:0]   res1_i,
    input  logic [LANES*WIDTH-1:0]   res2_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [LANES*WIDTH-1:0]   wb_data1_o,
    output logic [LANES*WIDTH-1:0]   wb_data2_o,
    output logic [2:0]               wb_stage_o,
    output logic [PARA-1:0]          wb_pos_o
);
    import stage2_pkg::*;

    localparam int LW = LANES * WIDTH;

    state_t          state_q;
    state_t          state_d;
    logic [PARA-1:0] step_q;
    logic            advance;
    logic            capture;
    logic            fifo_full;
    logic            fifo_empty;
    logic [3*LW-1:0] fifo_din;
    logic [3*LW-1:0] fifo_dout;

    assign fifo_din = {in_norm_i, in_scale_i, in_operand_i};

    stage2_fifo #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK_i   (CLK_i),
        .RST_i   (RST_i),
        .push_i  (in_valid_i),
        .pop_i   (advance),
        .data_i  (fifo_din),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready_o = ~fifo_full;
    assign advance    = (state_q == S_RUN) & ~fifo_empty
                      & (~wb_valid_o | wb_ready_i);
    assign stall_o    = ~advance;

`ifdef STAGE2_FEEDER_WB_FILTER_EN
    assign capture = advance & wb_stage_sel(stage_i);
`else
    assign capture = advance;
`endif

    // An empty FIFO presents zeros rather than a stale entry.
    assign {norm_o, scale_o, operand_o} = fifo_empty ? '0 : fifo_dout;

    // Positions are only meaningful while running; zero otherwise.
    always_comb begin
        pos_o = '0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < LANES; i++) begin
                pos_o[i*WIDTH +: WIDTH] = WIDTH'(step_q) * WIDTH'(LANES)
                                        + WIDTH'(i);
            end
        end
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (finished_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (!wb_valid_o) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            step_q <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            step_q <= '0;
        end else if (advance) begin
            step_q <= step_q + 1'b1;
        end
    end

    // A capture that coincides with acceptance simply overwrites the slot.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            wb_valid_o <= 1'b0;
            wb_data1_o <= '0;
            wb_data2_o <= '0;
            wb_stage_o <= '0;
            wb_pos_o   <= '0;
        end else if (capture) begin
            wb_valid_o <= 1'b1;
            wb_data1_o <= res1_i;
            wb_data2_o <= res2_i;
            wb_stage_o <= stage_i;
            wb_pos_o   <= step_q;
        end else if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage2_feeder.sv
// Directed self-checking bench for stage2_feeder.
// Covers reset, basic flow, FIFO full, backpressure, step wrap, reset, drain.
module tb_stage2_feeder;

    logic        CLK_i = 1'b0;
    logic        RST_i = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_operand_i = '0;
    logic [31:0] in_scale_i = '0;
    logic [31:0] in_norm_i = '0;
    logic        stall_o;
    logic [31:0] operand_o;
    logic [31:0] scale_o;
    logic [31:0] norm_o;
    logic [31:0] pos_o;
    logic [2:0]  stage_i = '0;
    logic        finished_i = 1'b0;
    logic [31:0] res1_i = '0;
    logic [31:0] res2_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [31:0] wb_data1_o;
    logic [31:0] wb_data2_o;
    logic [2:0]  wb_stage_o;
    logic [7:0]  wb_pos_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    stage2_feeder #(
        .WIDTH (16),
        .LANES (2),
        .PARA  (8),
        .DEPTH (4)
    ) dut (
        .CLK_i        (CLK_i),
        .RST_i        (RST_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_operand_i (in_operand_i),
        .in_scale_i   (in_scale_i),
        .in_norm_i    (in_norm_i),
        .stall_o      (stall_o),
        .operand_o    (operand_o),
        .scale_o      (scale_o),
        .norm_o       (norm_o),
        .pos_o        (pos_o),
        .stage_i      (stage_i),
        .finished_i   (finished_i),
        .res1_i       (res1_i),
        .res2_i       (res2_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_data1_o   (wb_data1_o),
        .wb_data2_o   (wb_data2_o),
        .wb_stage_o   (wb_stage_o),
        .wb_pos_o     (wb_pos_o)
    );

    always #5 CLK_i = ~CLK_i;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK_i);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    function automatic logic [31:0] op(input int k);
        return {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
    endfunction

    task automatic set_beat(input int k);
        in_operand_i = op(k);
        in_scale_i   = op(k) ^ 32'hFFFF_0000;
        in_norm_i    = op(k) + 32'h0303_0303;
    endtask

    task automatic push(input int k);
        in_valid_i = 1'b1;
        set_beat(k);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic do_start;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic finish_run;
        int i;
        finished_i = 1'b1;
        wb_ready_i = 1'b1;
        tick();
        finished_i = 1'b0;
        i = 0;
        while (!done_o && i < 20) begin
            tick();
            i++;
        end
        check("run_done", done_o, 1);
        tick();
        check("run_idle", busy_o, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        settle();
        check("rst_in_ready", in_ready_o, 1);
        check("rst_stall", stall_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_pos", pos_o, 0);
        check("rst_operand", operand_o, 0);
        check("rst_wb_data1", wb_data1_o, 0);
        RST_i = 1'b0;
        tick();

        // Basic flow: 3 beats, ready writeback
        push(0);
        push(1);
        push(2);
        settle();
        check("basic_head", operand_o, op(0));
        check("basic_scale", scale_o, op(0) ^ 32'hFFFF_0000);
        check("basic_norm", norm_o, op(0) + 32'h0303_0303);
        check("basic_idle_stall", stall_o, 1);
        do_start();
        wb_ready_i = 1'b1;
        stage_i    = 3'd3;
        for (int k = 0; k < 3; k++) begin
            res1_i     = 32'hA000 + 32'(k);
            res2_i     = 32'hC000 + 32'(k);
            finished_i = (k == 2);
            settle();
            check("basic_stall", stall_o, 0);
            check("basic_pos0", pos_o[15:0], 64'(2 * k));
            check("basic_operand", operand_o, op(k));
            tick();
            check("basic_wb_valid", wb_valid_o, 1);
            check("basic_wb_pos", wb_pos_o, 64'(k));
            check("basic_wb_data1", wb_data1_o, 32'hA000 + 32'(k));
        end
        finished_i = 1'b0;
        settle();
        check("basic_drain_busy", busy_o, 1);
        check("basic_drain_stall", stall_o, 1);
        check("basic_wb_stage", wb_stage_o, 3);
        check("basic_wb_data2", wb_data2_o, 32'hC002);
        tick();
        check("basic_accept", wb_valid_o, 0);
        check("basic_done_early", done_o, 0);
        tick();
        check("basic_done", done_o, 1);
        check("basic_done_busy", busy_o, 0);
        tick();
        check("basic_done_once", done_o, 0);
        wb_ready_i = 1'b0;

        // FIFO full in IDLE
        in_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(10 + k);
            settle();
            check("full_ready", in_ready_o, 1);
            tick();
        end
        set_beat(14);
        settle();
        check("full_not_ready", in_ready_o, 0);
        tick();
        check("full_hold", in_ready_o, 0);
        check("full_head", operand_o, op(10));
        in_valid_i = 1'b0;
        do_start();
        wb_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("full_pop_stall", stall_o, 0);
            check("full_pop_order", operand_o, op(10 + k));
            tick();
        end
        settle();
        check("full_empty_stall", stall_o, 1);
        check("full_empty_ready", in_ready_o, 1);
        finish_run();

        // Writeback backpressure
        push(20);
        push(21);
        wb_ready_i = 1'b0;
        do_start();
        res1_i = 32'h0000_C0C0;
        settle();
        check("bp_first_adv", stall_o, 0);
        tick();
        check("bp_wb_valid", wb_valid_o, 1);
        res1_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("bp_stall", stall_o, 1);
            check("bp_data_hold", wb_data1_o, 32'h0000_C0C0);
            check("bp_pos_hold", wb_pos_o, 0);
            tick();
        end
        wb_ready_i = 1'b1;
        res1_i = 32'h0000_C1C1;
        settle();
        check("bp_release", stall_o, 0);
        check("bp_next_head", operand_o, op(21));
        tick();
        check("bp_replace_valid", wb_valid_o, 1);
        check("bp_replace_data", wb_data1_o, 32'h0000_C1C1);
        check("bp_replace_pos", wb_pos_o, 1);
        finish_run();

        // Step wrap over 257 advances
        do_start();
        wb_ready_i = 1'b1;
        in_valid_i = 1'b1;
        set_beat(30);
        cnt = 0;
        for (int c = 0; c < 400 && cnt < 257; c++) begin
            settle();
            if (!stall_o) begin
                cnt++;
                if (cnt == 256) begin
                    check("wrap_pos_255", pos_o, 32'h01FF_01FE);
                end
                if (cnt == 257) begin
                    check("wrap_pos_0", pos_o, 32'h0001_0000);
                    in_valid_i = 1'b0;
                end
            end
            tick();
        end
        check("wrap_count", 64'(cnt), 257);
        check("wrap_wb_pos", wb_pos_o, 0);
        finish_run();

        // Mid-run reset with beats queued
        push(40);
        push(41);
        push(42);
        wb_ready_i = 1'b0;
        res1_i = 32'h0000_1234;
        do_start();
        settle();
        check("mrst_adv", stall_o, 0);
        tick();
        settle();
        check("mrst_busy_pre", busy_o, 1);
        check("mrst_wbv_pre", wb_valid_o, 1);
        RST_i = 1'b1;
        #1;
        check("mrst_in_ready", in_ready_o, 1);
        check("mrst_wb_valid", wb_valid_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_stall", stall_o, 1);
        check("mrst_operand", operand_o, 0);
        check("mrst_wb_data1", wb_data1_o, 0);
        tick();
        RST_i = 1'b0;
        tick();
        push(50);
        settle();
        check("mrst_new_head", operand_o, op(50));
        do_start();
        wb_ready_i = 1'b1;
        settle();
        check("mrst_run_head", operand_o, op(50));
        check("mrst_run_pos", pos_o, 32'h0001_0000);
        finish_run();

        // Drain: finished with pending, unaccepted writeback
        push(60);
        wb_ready_i = 1'b0;
        do_start();
        res1_i = 32'h0000_D00D;
        finished_i = 1'b1;
        settle();
        check("drain_adv", stall_o, 0);
        tick();
        finished_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("drain_hold_busy", busy_o, 1);
            check("drain_hold_done", done_o, 0);
            check("drain_hold_wbv", wb_valid_o, 1);
            tick();
        end
        check("drain_data", wb_data1_o, 32'h0000_D00D);
        wb_ready_i = 1'b1;
        settle();
        check("drain_accept_done", done_o, 0);
        tick();
        check("drain_wbv_clear", wb_valid_o, 0);
        check("drain_done_wait", done_o, 0);
        tick();
        check("drain_done", done_o, 1);
        tick();
        check("drain_done_once", done_o, 0);
        check("drain_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
